fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core, directly upstream of the control unit. Holds the PC, issues single-outstanding requests to the instruction memory/cache, and buffers returned words in a small prefetch FIFO. It presents the head instruction with its PC and pre-sliced `opcode`/`func3`/`func7` fields to decode. Honours redirects (`pcloadEn`/`pcTarget`) and decode stalls.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `FIFO_DEPTH`, default 2: prefetch entries; allowed values are 2 and 4.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `imemReq`, out, 1: fetch request (registered).
- `imemAddr`, out, 32: fetch address, word aligned (registered).
- `imemAck`, in, 1: response valid; completes the request.
- `imemData`, in, 32: instruction word, valid with `imemAck`.
- `pcloadEn`, in, 1: redirect request.
- `pcTarget`, in, 32: redirect target; bits [1:0] are ignored and forced to 0.
- `stall`, in, 1: decode stall (cache busy or hazard); head is not consumed.
- `instValid`, out, 1: head entry valid.
- `instr`, out, 32: head instruction; `32'h0000_0013` (NOP) when `instValid`=0.
- `instPc`, out, 32: PC of head instruction.
- `opcode`, out, 7: `instr[6:0]`.
- `func3`, out, 3: `instr[14:12]`.
- `func7`, out, 1: `instr[30]`.

## Operation
- FSM has three states:
  - IDLE: no request outstanding.
  - REQ: request outstanding; its data will be kept.
  - DROP: request outstanding; its data will be discarded after a redirect.
- **IDLE → REQ** when `count < FIFO_DEPTH` and no redirect. Drive `imemReq`=1 and `imemAddr`=pc.
- **REQ.** `imemReq`/`imemAddr` stay stable until `imemAck`.
  - On ack: push {pc, `imemData`}, pc += 4.
  - After the ack, go to REQ again if there is room, else IDLE.
- **Redirect** (`pcloadEn`=1), in any state:
  - FIFO flushed, count = 0.
  - pc = {`pcTarget`[31:2], 2'b00}.
  - The pop that cycle is suppressed.
  - If a request is outstanding and `imemAck`=0, go to DROP.
- **DROP.** `imemReq` held, with the old address, until `imemAck`. That data is discarded. Then go to REQ at the current pc.
- **Redirect with `imemAck` in the same cycle:** the acked data is discarded, pc = target, and there is no DROP. The next request starts the following cycle.
- **Redirect while in DROP:** pc is updated to the new target and the FSM stays in DROP.
- **Pop:** `instValid` && !`stall` && !`pcloadEn`.
- **Push and pop in the same cycle:** count unchanged.
- **No overflow:** one outstanding request and issue only when count < DEPTH guarantee it.
- **pc arithmetic:** 32-bit, wraps `32'hFFFF_FFFC` → `32'h0000_0000` with no flag.
- **Reset mid-request:** the response is ignored. State is IDLE and `imemReq`=0 during reset, and REQ starts after `rst_n` rises.

## Timing
- Reset values:
  - `imemReq`=0, `imemAddr`=`RESET_PC`.
  - `instValid`=0, `instr`=NOP, `instPc`=`RESET_PC`.
  - `opcode`=`7'b0010011`, `func3`=0, `func7`=0.
  - pc=`RESET_PC`, count=0.
- The first `imemReq` is asserted in the first cycle after `rst_n` deasserts.
- `imemAck` may arrive in the same cycle `imemReq` first rises (zero-wait memory). This gives 1 instruction/cycle sustained throughput.
- Ack at edge N → `instValid`=1 from cycle N+1 (FIFO output registered).
- Redirect at edge N → `instValid`=0 in cycle N+1.
  - Zero-wait memory: the target instruction is valid at N+2 at the earliest.
  - The DROP case adds the remaining wait cycles of the dropped request.
- `stall` has no effect on fetching. Requests continue until the FIFO is full.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` (`32'h0000_0013`).
  - Opcode constants (R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), reused by the control unit.
  - Fetch FSM state enum.
- Sub-module `fetch_fifo`:
  - Synchronous FIFO, parameterised on width (64: PC+instr) and depth.
  - Ports: push, pop, flush, full, empty, head.
  - Flush has priority over push.

## Test plan
- **Reset/first fetch:** hold `rst_n`=0 for 3 cycles with `imemAck`=1 → `imemReq`=0, `instr`=NOP. After release, `imemAddr`=0x0. Zero-wait memory returning 0x00500093 → `instValid`=1 next cycle, `instPc`=0, `opcode`=0x13.
- **Back-pressure:** `stall`=1, zero-wait memory → exactly `FIFO_DEPTH` pushes (PCs 0x0, 0x4), then `imemReq`=0. Release `stall` → instructions appear in order, none lost or duplicated.
- **Redirect in REQ with 3-cycle memory latency:** `pcloadEn`=1, `pcTarget`=0x103 in wait cycle 1 → FIFO empties, `imemAddr` holds the old address until ack. The word is discarded, next `imemAddr`=0x100, first valid `instPc`=0x100.
- **Redirect coincident with `imemAck`:** acked word never reaches `instValid`. Next request is 0x200 for `pcTarget`=0x200.
- **Wrap:** `pcTarget`=0xFFFF_FFFC → following fetch address 0x0000_0000.
- **Mid-request reset:** assert `rst_n`=0 during an outstanding request, then ack → no push. After release, `imemAddr`=`RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: the NOP encoding, the major opcodes
// used by decode and control, and the fetch FSM state type.
package riscv_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes (instr[6:0]) reused by the control unit
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Prefetch occupancy counter width; covers depths of 2 and 4
    localparam int FIFO_CNT_W = 3;

    // IDLE: nothing outstanding, REQ: outstanding and kept, DROP: outstanding and discarded
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

    // Force an address onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO. Head is read straight from the entry
// registers so a word pushed at one edge is visible right after that edge.
// Flush has priority over push and pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic                  full,
    output logic                  empty,
    output logic [WIDTH-1:0]      head,
    output logic [FIFO_CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_count == FIFO_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !flush && !full;
    assign w_do_pop  = pop && !flush && !empty;

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight to
// instruction memory, buffers returned words in a prefetch FIFO and presents
// the head instruction with its PC and pre-sliced fields to decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    input  logic        pcloadEn,
    input  logic [31:0] pcTarget,
    input  logic        stall,
    output logic        instValid,
    output logic [31:0] instr,
    output logic [31:0] instPc,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic        func7
);

    fetch_state_t          r_state;
    logic                  r_imem_req;
    logic [31:0]           r_imem_addr;
    logic [31:0]           r_pc;

    logic [31:0]           w_target;
    logic [31:0]           w_pc_inc;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [63:0]           w_head;
    logic [FIFO_CNT_W-1:0] w_count;
    logic                  w_room_after_ack;
    logic                  w_inst_valid;
    logic [31:0]           w_instr;

    assign w_target     = align_word(pcTarget);
    assign w_pc_inc     = r_pc + 32'd4;
    assign w_inst_valid = !w_empty;

    // Only a kept request delivers data; a same-cycle redirect discards it
    assign w_push = (r_state == FETCH_REQ) && imemAck && !pcloadEn;
    assign w_pop  = w_inst_valid && !stall && !pcloadEn;

    // After this ack's push (and any pop) will there still be a free slot?
    assign w_room_after_ack = w_pop || (w_count < FIFO_CNT_W'(FIFO_DEPTH - 1));

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (pcloadEn),
        .din   ({r_imem_addr, imemData}),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head),
        .count (w_count)
    );

    // Fetch FSM: request issue, ack handling, redirect and drop of stale responses.
    // In REQ r_pc equals the outstanding address; in DROP it holds the redirect target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FETCH_IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
            r_pc        <= RESET_PC;
        end else if (pcloadEn) begin
            r_pc <= w_target;
            if ((r_state != FETCH_IDLE) && !imemAck) begin
                // Request still in flight: keep it on the bus, throw its data away
                r_state <= FETCH_DROP;
            end else begin
                // Bus is free (idle or completing now): start on the target next cycle
                r_state     <= FETCH_REQ;
                r_imem_req  <= 1'b1;
                r_imem_addr <= w_target;
            end
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    if (!w_full) begin
                        r_state     <= FETCH_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_pc;
                    end
                end
                FETCH_REQ: begin
                    if (imemAck) begin
                        r_pc <= w_pc_inc;
                        if (w_room_after_ack) begin
                            r_imem_addr <= w_pc_inc;
                        end else begin
                            r_state    <= FETCH_IDLE;
                            r_imem_req <= 1'b0;
                        end
                    end
                end
                FETCH_DROP: begin
                    if (imemAck) begin
                        r_state     <= FETCH_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_pc;
                    end
                end
                default: begin
                    r_state    <= FETCH_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign w_instr = w_inst_valid ? w_head[31:0] : NOP_INSTR;

    assign imemReq   = r_imem_req;
    assign imemAddr  = r_imem_addr;
    assign instValid = w_inst_valid;
    assign instr     = w_instr;
    assign instPc    = w_inst_valid ? w_head[63:32] : r_pc;
    assign opcode    = w_instr[6:0];
    assign func3     = w_instr[14:12];
    assign func7     = w_instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder with variable latency, directed
// scenarios plus a randomized phase, and a scoreboard holding the expected
// sequential instruction stream since the last reset or redirect.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        pcloadEn;
    logic [31:0] pcTarget;
    logic        stall;
    logic        instValid;
    logic [31:0] instr;
    logic [31:0] instPc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemAck   (imemAck),
        .imemData  (imemData),
        .pcloadEn  (pcloadEn),
        .pcTarget  (pcTarget),
        .stall     (stall),
        .instValid (instValid),
        .instr     (instr),
        .instPc    (instPc),
        .opcode    (opcode),
        .func3     (func3),
        .func7     (func7)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb_q[$];
    logic [31:0] sb_next_pc;
    int          mem_lat;
    logic        force_ack;
    int          wait_cnt;
    int          ack_count;
    logic        p_req, p_ack, p_rst;
    logic [31:0] p_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ {a[7:0], 24'h000013};
    endfunction

    task automatic sb_top_up();
        while (sb_q.size() < 16) begin
            sb_q.push_back({sb_next_pc, mem_word(sb_next_pc)});
            sb_next_pc = sb_next_pc + 32'd4;
        end
    endtask

    // After reset or redirect the consumed stream restarts, sequential from start
    task automatic sb_restart(input logic [31:0] start);
        sb_q.delete();
        sb_next_pc = {start[31:2], 2'b00};
        sb_top_up();
    endtask

    // Memory responder: ack once the current request has waited mem_lat cycles
    task automatic mem_drive();
        if (force_ack) begin
            imemAck  = 1'b1;
            imemData = $urandom;
            wait_cnt = 0;
        end else if (!imemReq || !rst_n) begin
            imemAck  = 1'b0;
            imemData = $urandom;
            wait_cnt = 0;
        end else begin
            if (!p_req || p_ack || !p_rst) wait_cnt = 0;
            else wait_cnt++;
            imemAck  = (wait_cnt >= mem_lat);
            imemData = imemAck ? mem_word(imemAddr) : $urandom;
        end
    endtask

    // Advance one clock, check bus protocol, then drive the memory response
    task automatic step();
        p_req  = imemReq;
        p_ack  = imemAck;
        p_rst  = rst_n;
        p_addr = imemAddr;
        @(posedge clk);
        #1;
        if (p_rst && p_req && !p_ack) begin
            chk("req_hold", {31'b0, imemReq}, 32'd1);
            chk("addr_hold", imemAddr, p_addr);
        end
        if (rst_n && imemReq) chk("addr_align", {30'b0, imemAddr[1:0]}, 32'd0);
        mem_drive();
        if (rst_n && imemReq && imemAck) ack_count++;
        sb_top_up();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        force_ack = 1'b1;
        sb_restart(RST_PC);
        repeat (2) step();
        force_ack = 1'b0;
        imemAck   = 1'b0;
        rst_n     = 1'b1;
    endtask

    // Monitor: every consumed instruction is popped from the scoreboard and compared
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!instValid) begin
                    chk("idle_instr", instr, NOP_INSTR);
                    chk("idle_opcode", {25'b0, opcode}, 32'h13);
                    chk("idle_func3", {29'b0, func3}, 32'd0);
                    chk("idle_func7", {31'b0, func7}, 32'd0);
                end else if (!stall && !pcloadEn) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_empty", instPc, 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        $display("consume pc=%h instr=%h", instPc, instr);
                        chk("inst_pc", instPc, e.pc);
                        chk("instr", instr, e.ins);
                        chk("opcode", {25'b0, opcode}, {25'b0, e.ins[6:0]});
                        chk("func3", {29'b0, func3}, {29'b0, e.ins[14:12]});
                        chk("func7", {31'b0, func7}, {31'b0, e.ins[30]});
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] old_addr;
        logic        found;
        logic        seen_fc;

        rst_n     = 1'b0;
        imemAck   = 1'b0;
        imemData  = '0;
        pcloadEn  = 1'b0;
        pcTarget  = '0;
        stall     = 1'b0;
        mem_lat   = 0;
        force_ack = 1'b1;
        wait_cnt  = 0;
        ack_count = 0;
        sb_restart(RST_PC);

        // Reset with imemAck held high, then first fetch from zero-wait memory
        repeat (3) begin
            step();
            chk("rst_req", {31'b0, imemReq}, 32'd0);
            chk("rst_instr", instr, NOP_INSTR);
            chk("rst_valid", {31'b0, instValid}, 32'd0);
        end
        chk("rst_addr", imemAddr, RST_PC);
        chk("rst_instpc", instPc, RST_PC);
        chk("rst_opcode", {25'b0, opcode}, 32'h13);
        force_ack = 1'b0;
        imemAck   = 1'b0;
        rst_n     = 1'b1;
        step();
        chk("first_req", {31'b0, imemReq}, 32'd1);
        chk("first_addr", imemAddr, 32'h0);
        step();
        chk("first_valid", {31'b0, instValid}, 32'd1);
        chk("first_pc", instPc, 32'h0);
        chk("first_instr", instr, 32'h0050_0093);
        chk("first_opcode", {25'b0, opcode}, 32'h13);

        // Back-pressure: exactly DEPTH pushes then the bus goes idle
        stall = 1'b1;
        do_reset();
        ack_count = 0;
        repeat (8) step();
        chk("bp_pushes", ack_count, DEPTH);
        chk("bp_req_idle", {31'b0, imemReq}, 32'd0);
        chk("bp_head_pc", instPc, 32'h0);
        stall = 1'b0;
        repeat (10) step();

        // Redirect during wait cycle 1 of a 3-cycle-latency request
        mem_lat = 3;
        do_reset();
        step();
        chk("r3_req", {31'b0, imemReq}, 32'd1);
        step();
        old_addr = imemAddr;
        pcloadEn = 1'b1;
        pcTarget = 32'h0000_0103;
        sb_restart(32'h100);
        step();
        pcloadEn = 1'b0;
        chk("r3_flush", {31'b0, instValid}, 32'd0);
        chk("r3_drop_req", {31'b0, imemReq}, 32'd1);
        chk("r3_drop_addr", imemAddr, old_addr);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imemAck) found = 1'b1;
            else step();
        end
        chk("r3_ack_seen", {31'b0, found}, 32'd1);
        step();
        chk("r3_next_req", {31'b0, imemReq}, 32'd1);
        chk("r3_next_addr", imemAddr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instValid) found = 1'b1;
            else step();
        end
        chk("r3_valid_seen", {31'b0, found}, 32'd1);
        chk("r3_first_pc", instPc, 32'h100);
        repeat (6) step();

        // Redirect in the same cycle as an ack
        mem_lat = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imemReq && imemAck) found = 1'b1;
            else step();
        end
        chk("ra_ack_seen", {31'b0, found}, 32'd1);
        pcloadEn = 1'b1;
        pcTarget = 32'h0000_0200;
        sb_restart(32'h200);
        step();
        pcloadEn = 1'b0;
        chk("ra_flush", {31'b0, instValid}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (imemReq && imemAddr == 32'h200) found = 1'b1;
            else step();
        end
        chk("ra_next_addr", {31'b0, found}, 32'd1);
        repeat (15) step();

        // PC wrap at the top of the address space
        mem_lat  = 0;
        pcloadEn = 1'b1;
        pcTarget = 32'hFFFF_FFFC;
        sb_restart(32'hFFFF_FFFC);
        step();
        pcloadEn = 1'b0;
        seen_fc = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (imemReq && imemAddr == 32'hFFFF_FFFC) seen_fc = 1'b1;
            if (seen_fc && imemReq && imemAddr == 32'h0) found = 1'b1;
            else step();
        end
        chk("wrap_top", {31'b0, seen_fc}, 32'd1);
        chk("wrap_zero", {31'b0, found}, 32'd1);
        repeat (10) step();

        // Reset while a request is outstanding; the ack during reset is ignored
        mem_lat  = 3;
        pcloadEn = 1'b1;
        pcTarget = 32'h0000_0300;
        sb_restart(32'h300);
        step();
        pcloadEn = 1'b0;
        step();
        rst_n     = 1'b0;
        force_ack = 1'b1;
        sb_restart(RST_PC);
        repeat (2) begin
            step();
            chk("mrst_req", {31'b0, imemReq}, 32'd0);
            chk("mrst_valid", {31'b0, instValid}, 32'd0);
        end
        force_ack = 1'b0;
        imemAck   = 1'b0;
        rst_n     = 1'b1;
        step();
        chk("mrst_req_after", {31'b0, imemReq}, 32'd1);
        chk("mrst_addr_after", imemAddr, RST_PC);
        repeat (12) step();

        // Randomized traffic: latency, stall, redirects (some near the wrap), rare resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) mem_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 399) == 0) begin
                pcloadEn = 1'b0;
                do_reset();
            end
            stall    = ($urandom_range(0, 99) < 30);
            pcTarget = $urandom;
            if ($urandom_range(0, 99) < 5) begin
                if ($urandom_range(0, 3) == 0) pcTarget = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else pcTarget = $urandom & 32'h0000_FFFF;
                pcloadEn = 1'b1;
                sb_restart(pcTarget);
            end else begin
                pcloadEn = 1'b0;
            end
            step();
        end
        pcloadEn = 1'b0;
        stall    = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
